// File: rtl/ddr_cmd_sched_pkg.sv
// Shared DDR controller definitions: command codes decoded by the
// transaction engine and the command scheduler FSM state encoding.
package ddr_cmd_sched_pkg;

  localparam int unsigned CMD_TYPE_W = 2;

  // Command codes on cmd_type
  typedef enum logic [CMD_TYPE_W-1:0] {
    CMD_READ    = 2'd0,
    CMD_WRITE   = 2'd1,
    CMD_REFRESH = 2'd2
  } cmd_type_e;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_e;

  // Direction of the most recent AW/AR grant, used for round-robin
  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/ddr_cmd_sched_ref_timer.sv
// ddr_ref_timer: refresh interval counter and postponed-refresh bookkeeping.
// Ports:
//   core_clk, core_rst_sync : clock, synchronous active-high reset
//   init_done               : interval counting enabled once DDR init is done
//   ref_dec                 : one-cycle pulse, a REFRESH command completed
//   ref_pending             : outstanding refresh count, saturates at REF_MAX
//   ref_overflow            : sticky, interval tick seen while pending==REF_MAX
module ddr_ref_timer #(
  parameter int unsigned TREFI_CYC = 780,
  parameter int unsigned REF_MAX   = 8,
  localparam int unsigned PEND_W   = $clog2(REF_MAX + 1)
) (
  input  logic              core_clk,
  input  logic              core_rst_sync,
  input  logic              init_done,
  input  logic              ref_dec,
  output logic [PEND_W-1:0] ref_pending,
  output logic              ref_overflow
);

  localparam int unsigned CNT_W = (TREFI_CYC > 1) ? $clog2(TREFI_CYC) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              tick;

  // Interval counter, tick generation and saturating pending counter
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    tick   = init_done && (cnt_q == CNT_W'(TREFI_CYC - 1));

    if (!init_done || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A tick and a completion in the same cycle cancel out
    if (tick && !ref_dec) begin
      if (pend_q != PEND_W'(REF_MAX)) begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (ref_dec && !tick) begin
      if (pend_q != '0) begin
        pend_d = pend_q - PEND_W'(1);
      end
    end

    if (tick && (pend_q == PEND_W'(REF_MAX))) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst_sync) begin
      cnt_q  <= '0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ref_pending  = pend_q;
  assign ref_overflow = ovf_q;

endmodule

// File: rtl/ddr_cmd_sched.sv
// ddr_cmd_sched: arbitrates AW/AR burst requests and refresh obligations,
// issuing one command at a time to the DDR transaction engine and waiting
// for its completion before the next decision.
// Ports:
//   core_clk, core_rst_sync          : clock, synchronous active-high reset
//   init_done                        : DDR init complete, enables scheduling
//   awvalid/awready/awaddr/awlen     : write request channel (ready is combinational)
//   arvalid/arready/araddr/arlen     : read request channel (ready is combinational)
//   cmd_valid/cmd_ready              : command handshake to transaction engine
//   cmd_type/cmd_addr/cmd_len        : registered command payload
//   cmd_done                         : completion pulse of the accepted command
//   ref_pending/ref_overflow         : refresh bookkeeping
//   busy                             : scheduler not in IDLE
module ddr_cmd_sched
  import ddr_cmd_sched_pkg::*;
#(
  parameter int unsigned BA_BITS    = 2,
  parameter int unsigned ROW_BITS   = 13,
  parameter int unsigned COL_BITS   = 10,
  parameter int unsigned DQ_LEVEL   = 1,
  parameter int unsigned TREFI_CYC  = 780,
  parameter int unsigned REF_MAX    = 8,
  parameter int unsigned REF_URGENT = 6,
  localparam int unsigned ADDR_W    = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1,
  localparam int unsigned PEND_W    = $clog2(REF_MAX + 1)
) (
  input  logic              core_clk,
  input  logic              core_rst_sync,
  input  logic              init_done,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_type,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  input  logic              cmd_done,
  output logic [PEND_W-1:0] ref_pending,
  output logic              ref_overflow,
  output logic              busy
);

  sched_state_e      state_q, state_d;
  logic              last_dir_q, last_dir_d;
  logic              cmd_valid_q, cmd_valid_d;
  cmd_type_e         cmd_type_q, cmd_type_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]        cmd_len_q, cmd_len_d;
  logic              busy_q, busy_d;
  logic              aw_grant, ar_grant, ref_grant, ref_dec;

  // Next-state, grant decision and command capture
  always_comb begin
    state_d     = state_q;
    last_dir_d  = last_dir_q;
    cmd_valid_d = cmd_valid_q;
    cmd_type_d  = cmd_type_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    busy_d      = busy_q;
    aw_grant    = 1'b0;
    ar_grant    = 1'b0;
    ref_grant   = 1'b0;
    ref_dec     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (init_done) begin
          if (ref_pending >= PEND_W'(REF_URGENT)) begin
            ref_grant = 1'b1;
          end else if (awvalid && !arvalid) begin
            aw_grant = 1'b1;
          end else if (arvalid && !awvalid) begin
            ar_grant = 1'b1;
          end else if (awvalid && arvalid) begin
            // Round-robin: serve the direction not granted last time
            if (last_dir_q == DIR_READ) aw_grant = 1'b1;
            else                        ar_grant = 1'b1;
          end else if (ref_pending != '0) begin
            ref_grant = 1'b1;
          end
        end

        if (aw_grant) begin
          cmd_type_d = CMD_WRITE;
          cmd_addr_d = awaddr;
          cmd_len_d  = awlen;
          last_dir_d = DIR_WRITE;
        end else if (ar_grant) begin
          cmd_type_d = CMD_READ;
          cmd_addr_d = araddr;
          cmd_len_d  = arlen;
          last_dir_d = DIR_READ;
        end else if (ref_grant) begin
          cmd_type_d = CMD_REFRESH;
          cmd_addr_d = '0;
          cmd_len_d  = '0;
        end

        if (aw_grant || ar_grant || ref_grant) begin
          state_d     = ST_ISSUE;
          cmd_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      ST_ISSUE: begin
        if (cmd_ready) begin
          state_d     = ST_WAIT;
          cmd_valid_d = 1'b0;
        end
      end

      ST_WAIT: begin
        if (cmd_done) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          ref_dec = (cmd_type_q == CMD_REFRESH);
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst_sync) begin
      state_q     <= ST_IDLE;
      last_dir_q  <= DIR_READ;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_READ;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      busy_q      <= busy_d;
    end
  end

  ddr_ref_timer #(
    .TREFI_CYC (TREFI_CYC),
    .REF_MAX   (REF_MAX)
  ) u_ref_timer (
    .core_clk      (core_clk),
    .core_rst_sync (core_rst_sync),
    .init_done     (init_done),
    .ref_dec       (ref_dec),
    .ref_pending   (ref_pending),
    .ref_overflow  (ref_overflow)
  );

  assign awready   = aw_grant;
  assign arready   = ar_grant;
  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Directed self-checking bench for ddr_cmd_sched with a command scoreboard.
module tb_ddr_cmd_sched;
  import ddr_cmd_sched_pkg::*;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned TREFI  = 16;
  localparam int unsigned RMAX   = 8;
  localparam int unsigned RURG   = 6;

  typedef struct packed {
    logic [1:0]        t;
    logic [ADDR_W-1:0] a;
    logic [7:0]        l;
  } exp_t;

  logic              core_clk = 1'b0;
  logic              core_rst_sync;
  logic              init_done;
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              cmd_done;
  logic [3:0]        ref_pending;
  logic              ref_overflow;
  logic              busy;

  int   checks = 0;
  int   errors = 0;
  int   c, n_acc, acc_cyc, done_cnt, done_dly;
  exp_t sb[$];

  always #5 core_clk = ~core_clk;

  ddr_cmd_sched #(
    .BA_BITS(2), .ROW_BITS(13), .COL_BITS(10), .DQ_LEVEL(1),
    .TREFI_CYC(TREFI), .REF_MAX(RMAX), .REF_URGENT(RURG)
  ) dut (
    .core_clk(core_clk), .core_rst_sync(core_rst_sync), .init_done(init_done),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done),
    .ref_pending(ref_pending), .ref_overflow(ref_overflow), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: monitor accepted commands against the scoreboard, then
  // advance and play the engine's completion pulse.
  task automatic cycle();
    exp_t e;
    #1;
    if (cmd_valid && cmd_ready) begin
      n_acc++;
      acc_cyc = c;
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_type", 32'(cmd_type), 32'(e.t));
        chk("sb_addr", 32'(cmd_addr), 32'(e.a));
        chk("sb_len",  32'(cmd_len),  32'(e.l));
      end
      if (done_dly > 0) done_cnt = done_dly;
    end
    @(posedge core_clk);
    #1;
    c++;
    cmd_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) cmd_done = 1'b1;
    end
  endtask

  task automatic reset_on();
    core_rst_sync = 1'b1;
    init_done = 1'b0;
    awvalid = 1'b0; arvalid = 1'b0;
    cmd_ready = 1'b0; cmd_done = 1'b0;
    done_cnt = 0; done_dly = 0;
    sb.delete();
    cycle();
    cycle();
  endtask

  task automatic reset_off();
    core_rst_sync = 1'b0;
    init_done = 1'b1;
    c = 0;
    n_acc = 0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_awready"},  32'(awready), 0);
    chk({pfx, "_arready"},  32'(arready), 0);
    chk({pfx, "_cmd_valid"}, 32'(cmd_valid), 0);
    chk({pfx, "_cmd_type"}, 32'(cmd_type), 0);
    chk({pfx, "_cmd_addr"}, 32'(cmd_addr), 0);
    chk({pfx, "_cmd_len"},  32'(cmd_len), 0);
    chk({pfx, "_pending"},  32'(ref_pending), 0);
    chk({pfx, "_overflow"}, 32'(ref_overflow), 0);
    chk({pfx, "_busy"},     32'(busy), 0);
  endtask

  initial begin
    core_rst_sync = 1'b1; init_done = 1'b0;
    awvalid = 1'b0; awaddr = '0; awlen = '0;
    arvalid = 1'b0; araddr = '0; arlen = '0;
    cmd_ready = 1'b0; cmd_done = 1'b0;
    c = 0; n_acc = 0; acc_cyc = 0; done_cnt = 0; done_dly = 0;
    @(posedge core_clk);
    #1;

    // Reset state
    reset_on();
    chk_reset_outputs("rst");

    // Single write with a held command before cmd_ready
    reset_off();
    awvalid = 1'b1; awaddr = 25'h1234; awlen = 8'd7;
    sb.push_back('{2'(CMD_WRITE), 25'h1234, 8'd7});
    #1;
    chk("w_awready", 32'(awready), 1);
    chk("w_arready", 32'(arready), 0);
    cycle();
    awvalid = 1'b0;
    chk("w_cmd_valid", 32'(cmd_valid), 1);
    chk("w_cmd_type", 32'(cmd_type), 1);
    chk("w_cmd_addr", 32'(cmd_addr), 32'h1234);
    chk("w_cmd_len", 32'(cmd_len), 7);
    chk("w_busy", 32'(busy), 1);
    cycle();
    chk("w_hold_valid", 32'(cmd_valid), 1);
    chk("w_hold_addr", 32'(cmd_addr), 32'h1234);
    cmd_ready = 1'b1; done_dly = 2;
    cycle();
    cmd_ready = 1'b0;
    chk("w_valid_drop", 32'(cmd_valid), 0);
    chk("w_busy_wait", 32'(busy), 1);
    cycle();
    chk("w_busy_at_done", 32'(busy), 1);
    cycle();
    chk("w_idle", 32'(busy), 0);
    chk("w_accepts", 32'(n_acc), 1);

    // Round-robin with both requests held
    reset_on();
    reset_off();
    sb.push_back('{2'(CMD_WRITE), 25'h100, 8'd3});
    sb.push_back('{2'(CMD_READ),  25'h200, 8'd5});
    sb.push_back('{2'(CMD_WRITE), 25'h100, 8'd3});
    sb.push_back('{2'(CMD_READ),  25'h200, 8'd5});
    awvalid = 1'b1; awaddr = 25'h100; awlen = 8'd3;
    arvalid = 1'b1; araddr = 25'h200; arlen = 8'd5;
    cmd_ready = 1'b1; done_dly = 4;
    #1;
    chk("rr_first_aw", 32'(awready), 1);
    chk("rr_first_ar", 32'(arready), 0);
    for (int i = 0; i < 60 && n_acc < 4; i++) cycle();
    awvalid = 1'b0; arvalid = 1'b0; cmd_ready = 1'b0;
    chk("rr_accepts", 32'(n_acc), 4);
    chk("rr_last_accept_cyc", 32'(acc_cyc), 19);

    // Continuous reads until refresh becomes urgent
    reset_on();
    reset_off();
    for (int i = 0; i < 24; i++) sb.push_back('{2'(CMD_READ), 25'h300, 8'd1});
    sb.push_back('{2'(CMD_REFRESH), 25'h0, 8'd0});
    arvalid = 1'b1; araddr = 25'h300; arlen = 8'd1;
    cmd_ready = 1'b1; done_dly = 2;
    for (int i = 0; i < 200 && n_acc < 25; i++) begin
      chk("urg_pending", 32'(ref_pending), 32'(c / 16));
      cycle();
    end
    arvalid = 1'b0; cmd_ready = 1'b0;
    chk("urg_accepts", 32'(n_acc), 25);
    chk("urg_ref_cyc", 32'(acc_cyc), 97);
    chk("urg_sb_empty", 32'(sb.size()), 0);

    // Idle refresh
    reset_on();
    reset_off();
    sb.push_back('{2'(CMD_REFRESH), 25'h0, 8'd0});
    cmd_ready = 1'b1; done_dly = 2;
    while (c < 15) cycle();
    chk("idle_pend_c15", 32'(ref_pending), 0);
    cycle();
    chk("idle_pend_c16", 32'(ref_pending), 1);
    chk("idle_busy_c16", 32'(busy), 0);
    cycle();
    chk("idle_ref_valid", 32'(cmd_valid), 1);
    chk("idle_ref_type", 32'(cmd_type), 2);
    cycle();
    chk("idle_ref_drop", 32'(cmd_valid), 0);
    cycle();
    chk("idle_pend_at_done", 32'(ref_pending), 1);
    cycle();
    chk("idle_pend_after", 32'(ref_pending), 0);
    chk("idle_busy_after", 32'(busy), 0);
    chk("idle_accepts", 32'(n_acc), 1);

    // Stuck command in ISSUE, pending saturation and overflow
    reset_on();
    reset_off();
    sb.push_back('{2'(CMD_WRITE), 25'h77, 8'd2});
    awvalid = 1'b1; awaddr = 25'h77; awlen = 8'd2;
    cycle();
    awvalid = 1'b0;
    while (c < 50) cycle();
    cmd_done = 1'b1;
    cycle();
    chk("ov_done_ignored_valid", 32'(cmd_valid), 1);
    chk("ov_done_ignored_busy", 32'(busy), 1);
    while (c < 127) cycle();
    chk("ov_pend_c127", 32'(ref_pending), 7);
    chk("ov_flag_c127", 32'(ref_overflow), 0);
    cycle();
    chk("ov_pend_c128", 32'(ref_pending), 8);
    chk("ov_flag_c128", 32'(ref_overflow), 0);
    while (c < 143) cycle();
    chk("ov_pend_c143", 32'(ref_pending), 8);
    chk("ov_flag_c143", 32'(ref_overflow), 0);
    cycle();
    chk("ov_flag_c144", 32'(ref_overflow), 1);
    chk("ov_pend_c144", 32'(ref_pending), 8);
    while (c < 170) cycle();
    chk("ov_flag_sticky", 32'(ref_overflow), 1);
    chk("ov_pend_sat", 32'(ref_pending), 8);
    chk("ov_stuck_valid", 32'(cmd_valid), 1);
    chk("ov_stuck_addr", 32'(cmd_addr), 32'h77);

    // Reset while a command is in WAIT, then normal service
    reset_on();
    reset_off();
    sb.push_back('{2'(CMD_WRITE), 25'h55, 8'd2});
    awvalid = 1'b1; awaddr = 25'h55; awlen = 8'd2;
    cmd_ready = 1'b1; done_dly = 10;
    cycle();
    awvalid = 1'b0;
    cycle();
    cycle();
    chk("mid_busy_wait", 32'(busy), 1);
    chk("mid_valid_wait", 32'(cmd_valid), 0);
    core_rst_sync = 1'b1;
    cmd_ready = 1'b0;
    done_cnt = 0; done_dly = 0;
    cycle();
    chk_reset_outputs("mid");
    reset_off();
    sb.push_back('{2'(CMD_WRITE), 25'hABC, 8'd4});
    awvalid = 1'b1; awaddr = 25'hABC; awlen = 8'd4;
    cmd_ready = 1'b1; done_dly = 2;
    #1;
    chk("post_awready", 32'(awready), 1);
    cycle();
    awvalid = 1'b0;
    chk("post_valid", 32'(cmd_valid), 1);
    chk("post_addr", 32'(cmd_addr), 32'hABC);
    cycle();
    cycle();
    cycle();
    chk("post_idle", 32'(busy), 0);
    chk("post_accepts", 32'(n_acc), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
